// File: rtl/karatsuba_pkg.sv
// Shared types and width helpers for the Karatsuba multiplier.
package karatsuba_pkg;

    // Control sequence: one state per Karatsuba term, then recombine and hold.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_LO  = 3'd1,
        MUL_HI  = 3'd2,
        MUL_MID = 3'd3,
        COMBINE = 3'd4,
        HOLD    = 3'd5
    } state_e;

    // Bits needed for a down-counter that starts at n and stops at 0.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/karatsuba_mult_seq_mult.sv
// Sequential shift-add unsigned multiplier, N x N -> 2N bits.
// A start cycle loads the operands; N iterations follow.
// done is high during the cycle of the final iteration, so p holds the
// finished product from the next edge onward and keeps it until restarted.
module seq_mult
    import karatsuba_pkg::*;
#(
    parameter int N = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [2*N-1:0]   p,
    output logic             done
);

    localparam int CW = cnt_width(N);

    logic [2*N-1:0] mcand_r;
    logic [2*N-1:0] acc_r;
    logic [N-1:0]   mplier_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           done_r;

    // Load on start, otherwise run one shift-add iteration per cycle while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= {(2*N){1'b0}};
            acc_r    <= {(2*N){1'b0}};
            mplier_r <= {N{1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= {{N{1'b0}}, a};
            acc_r    <= {(2*N){1'b0}};
            mplier_r <= b;
            cnt_r    <= CW'(N);
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
        end else if (busy_r) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end else begin
                acc_r <= acc_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r - CW'(1);
            busy_r   <= (cnt_r != CW'(1));
            // Flag the upcoming cycle as the one carrying the last iteration.
            done_r   <= (cnt_r == CW'(2));
        end else begin
            done_r   <= 1'b0;
        end
    end

    assign p    = acc_r;
    assign done = done_r;

endmodule

// File: rtl/karatsuba_mult.sv
// Karatsuba multiplier: three half-width products on one shared sequential
// multiplier, recombined into a W x W -> 2W product with optional sign.
module karatsuba_mult
    import karatsuba_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           signed_mode,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] P,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int H = W / 2;
    localparam int N = H + 1;

    state_e         state_r;
    state_e         state_nxt_s;
    logic           start_r;
    logic           start_nxt_s;
    logic           in_ready_r;
    logic           out_valid_r;

    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           neg_r;
    logic [2*N-1:0] z0_r;
    logic [2*N-1:0] z2_r;
    logic [2*W-1:0] p_r;

    logic [W-1:0]   a_mag_s;
    logic [W-1:0]   b_mag_s;
    logic           neg_in_s;
    logic           accept_s;

    logic [N-1:0]   op_a_s;
    logic [N-1:0]   op_b_s;
    logic [2*N-1:0] mult_p_s;
    logic           mult_done_s;

    logic [2*N-1:0] mid_s;
    logic [2*W-1:0] z0_ext_s;
    logic [2*W-1:0] z2_ext_s;
    logic [2*W-1:0] mid_ext_s;
    logic [2*W-1:0] mag_s;
    logic [2*W-1:0] p_nxt_s;

    assign accept_s = (state_r == IDLE) && in_valid;

    // Sign pre-processing: magnitudes plus result sign; -2^(W-1) maps to 2^(W-1).
    always_comb begin
        a_mag_s  = A;
        b_mag_s  = B;
        neg_in_s = 1'b0;
        if (signed_mode) begin
            if (A[W-1]) begin
                a_mag_s = ~A + W'(1);
            end else begin
                a_mag_s = A;
            end
            if (B[W-1]) begin
                b_mag_s = ~B + W'(1);
            end else begin
                b_mag_s = B;
            end
            neg_in_s = A[W-1] ^ B[W-1];
        end else begin
            a_mag_s  = A;
            b_mag_s  = B;
            neg_in_s = 1'b0;
        end
    end

    // Select the sub-multiplier operands for the term being computed.
    always_comb begin
        op_a_s = {N{1'b0}};
        op_b_s = {N{1'b0}};
        case (state_r)
            MUL_LO: begin
                op_a_s = {1'b0, a_r[H-1:0]};
                op_b_s = {1'b0, b_r[H-1:0]};
            end
            MUL_HI: begin
                op_a_s = {1'b0, a_r[W-1:H]};
                op_b_s = {1'b0, b_r[W-1:H]};
            end
            MUL_MID: begin
                // Half sums keep their carry in the extra operand bit.
                op_a_s = {1'b0, a_r[H-1:0]} + {1'b0, a_r[W-1:H]};
                op_b_s = {1'b0, b_r[H-1:0]} + {1'b0, b_r[W-1:H]};
            end
            default: begin
                op_a_s = {N{1'b0}};
                op_b_s = {N{1'b0}};
            end
        endcase
    end

    // Recombine the three terms; zm is still held on the multiplier output.
    // The true magnitude is below 2^(2W), so 2W-bit modular sums are exact.
    always_comb begin
        mid_s     = mult_p_s - z2_r - z0_r;
        z0_ext_s  = {{(2*W-2*N){1'b0}}, z0_r};
        z2_ext_s  = {{(2*W-2*N){1'b0}}, z2_r};
        mid_ext_s = {{(2*W-2*N){1'b0}}, mid_s};
        mag_s     = (z2_ext_s << W) + (mid_ext_s << H) + z0_ext_s;
        if (neg_r) begin
            p_nxt_s = ~mag_s + (2*W)'(1);
        end else begin
            p_nxt_s = mag_s;
        end
    end

    // Next-state logic; start is raised on entry to each multiply state.
    always_comb begin
        state_nxt_s = state_r;
        start_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = MUL_LO;
                    start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL_LO: begin
                if (mult_done_s) begin
                    state_nxt_s = MUL_HI;
                    start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = MUL_LO;
                end
            end
            MUL_HI: begin
                if (mult_done_s) begin
                    state_nxt_s = MUL_MID;
                    start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = MUL_HI;
                end
            end
            MUL_MID: begin
                if (mult_done_s) begin
                    state_nxt_s = COMBINE;
                end else begin
                    state_nxt_s = MUL_MID;
                end
            end
            COMBINE: begin
                state_nxt_s = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            start_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            start_r     <= start_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == HOLD);
        end
    end

    // Operand capture, term capture (one cycle after each term finishes) and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= {W{1'b0}};
            b_r   <= {W{1'b0}};
            neg_r <= 1'b0;
            z0_r  <= {(2*N){1'b0}};
            z2_r  <= {(2*N){1'b0}};
            p_r   <= {(2*W){1'b0}};
        end else begin
            if (accept_s) begin
                a_r   <= a_mag_s;
                b_r   <= b_mag_s;
                neg_r <= neg_in_s;
            end
            if ((state_r == MUL_HI) && start_r) begin
                z0_r <= mult_p_s;
            end
            if ((state_r == MUL_MID) && start_r) begin
                z2_r <= mult_p_s;
            end
            if (state_r == COMBINE) begin
                p_r <= p_nxt_s;
            end
        end
    end

    seq_mult #(
        .N (N)
    ) u_seq_mult (
        .clk   (clk),
        .rst   (rst),
        .start (start_r),
        .a     (op_a_s),
        .b     (op_b_s),
        .p     (mult_p_s),
        .done  (mult_done_s)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign P         = p_r;

endmodule
